// File: rtl/hazard_forward_unit.sv
// Hazard unit for the 5-stage core: prioritised EX operand forwarding,
// load-use stall sequencing in ID, branch flush, and saturating
// performance counters for stall cycles and flush events.
module hazard_forward_unit #(
    parameter int NUM_SRC  = 3,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = $clog2(NUM_SRC + 1)
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [6:0]               opcode_id,
    input  logic [REG_W-1:0]         rs1_id,
    input  logic [REG_W-1:0]         rs2_id,
    input  logic [6:0]               opcode_ex,
    input  logic [REG_W-1:0]         rs1_ex,
    input  logic [REG_W-1:0]         rs2_ex,
    input  logic [REG_W-1:0]         rd_ex,
    input  logic                     mem_read_ex,
    input  logic                     branch_taken_ex,
    input  logic [NUM_SRC-1:0]       reg_write_src,
    input  logic [NUM_SRC*REG_W-1:0] rd_src,
    output logic [SEL_W-1:0]         forwardA,
    output logic [SEL_W-1:0]         forwardB,
    output logic                     stall_pc,
    output logic                     stall_if_id,
    output logic                     bubble_id_ex,
    output logic                     flush_if_id,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [CNT_W-1:0]         flush_events
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state;
    logic [3:0] cnt;

    // R, S, B and I formats read rs1; everything else reads no register.
    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0100011, 7'b1100011,
            7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
            default:                            uses_rs1 = 1'b0;
        endcase
    endfunction

    // Only R, S and B formats read rs2.
    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0100011, 7'b1100011: uses_rs2 = 1'b1;
            default:                            uses_rs2 = 1'b0;
        endcase
    endfunction

    logic [NUM_SRC-1:0] hit_a;
    logic [NUM_SRC-1:0] hit_b;

    // Per-source match; x0 is hard-wired zero so it never forwards.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_W-1:0] rd_k;
            assign rd_k      = rd_src[gi*REG_W +: REG_W];
            assign hit_a[gi] = reg_write_src[gi] && (rd_k != '0) && (rd_k == rs1_ex);
            assign hit_b[gi] = reg_write_src[gi] && (rd_k != '0) && (rd_k == rs2_ex);
        end
    endgenerate

    // Priority select: scanning oldest to youngest lets the youngest hit win.
    always_comb begin
        forwardA = '0;
        forwardB = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (uses_rs1(opcode_ex) && hit_a[k]) forwardA = SEL_W'(k + 1);
            if (uses_rs2(opcode_ex) && hit_b[k]) forwardB = SEL_W'(k + 1);
        end
    end

    logic luse;
    logic stall;

    // Load-use in ID, plus stall/flush decode; reset masks all control outputs.
    always_comb begin
        luse = mem_read_ex && (rd_ex != '0) &&
               ((uses_rs1(opcode_id) && (rd_ex == rs1_id)) ||
                (uses_rs2(opcode_id) && (rd_ex == rs2_id)));
        stall        = RESET_N && !branch_taken_ex &&
                       ((state == HOLD) || ((state == IDLE) && luse));
        stall_pc     = stall;
        stall_if_id  = stall;
        flush_if_id  = RESET_N && branch_taken_ex;
        bubble_id_ex = stall || flush_if_id;
    end

    // Stall sequencer: the first stall cycle is spent in IDLE, the
    // remaining LOAD_LAT-1 cycles in HOLD; a taken branch cancels it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (branch_taken_ex) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (luse) begin
                        cnt   <= 4'(LOAD_LAT - 1);
                        state <= (LOAD_LAT > 1) ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating event counters for performance debug.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_pc && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
            if (flush_if_id && (flush_events != '1)) flush_events <= flush_events + 1'b1;
        end
    end

endmodule
